// File: rtl/clock_tick_divider.sv
// Programmable synchronous divider: one-cycle tick enable, live phase count, optional square wave.
// Optional feature macro: DIVIDER_SQUARE_EN (square-wave output; tied low when undefined).
module clock_tick_divider #(
   parameter int          WIDTH       = 24,
   parameter int unsigned DEFAULT_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   input  logic             oneshot,
   input  logic             start,
   output logic             tick,
   output logic             sq_out,
   output logic [WIDTH-1:0] count,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] div_reg, div_next;
   logic [WIDTH-1:0] pend_reg, pend_next;
   logic             pend_v_reg, pend_v_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic             tick_reg, tick_next;
   logic             ack_reg, ack_next;
   logic             load_ok;
   logic             apply;

   // Phase counter and mode control; a pending divisor is only applied at a period boundary.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      tick_next  = 1'b0;
      apply      = 1'b0;
      case (state_reg)
         IDLE: begin
            count_next = '0;
            apply      = pend_v_reg;
            if (!oneshot || start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (start) begin
               count_next = '0;
               apply      = pend_v_reg;
            end else if (en) begin
               if (count_reg == div_reg - 1'b1) begin
                  count_next = '0;
                  tick_next  = 1'b1;
                  apply      = pend_v_reg;
                  if (oneshot) begin
                     state_next = IDLE;
                  end
               end else begin
                  count_next = count_reg + 1'b1;
               end
            end
         end
         default: state_next = RUN;
      endcase
   end

   // A zero divisor request is dropped; a newer request overwrites an unapplied one.
   always_comb begin
      load_ok     = div_load && (div_val != '0);
      pend_next   = load_ok ? div_val : pend_reg;
      pend_v_next = load_ok | (pend_v_reg & ~apply);
      div_next    = apply ? pend_reg : div_reg;
      ack_next    = apply;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= RUN;
         div_reg    <= WIDTH'(DEFAULT_DIV);
         pend_reg   <= '0;
         pend_v_reg <= 1'b0;
         count_reg  <= '0;
         tick_reg   <= 1'b0;
         ack_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         div_reg    <= div_next;
         pend_reg   <= pend_next;
         pend_v_reg <= pend_v_next;
         count_reg  <= count_next;
         tick_reg   <= tick_next;
         ack_reg    <= ack_next;
      end
   end

`ifdef DIVIDER_SQUARE_EN
   logic sq_reg, sq_next;

   // Compared against the divisor of the period that starts on this edge.
   always_comb begin
      sq_next = (state_next == RUN) && (count_next < (div_next >> 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_reg <= 1'b0;
      end else begin
         sq_reg <= sq_next;
      end
   end

   assign sq_out = sq_reg;
`else
   assign sq_out = 1'b0;
`endif

   assign tick    = tick_reg;
   assign div_ack = ack_reg;
   assign count   = count_reg;
   assign busy    = (state_reg == RUN);

endmodule

// File: tb/tb_clock_tick_divider.sv
// Directed bench for clock_tick_divider: expected per-cycle outputs go through a scoreboard queue.
module tb_clock_tick_divider;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [W-1:0] div_val;
   logic         div_load;
   logic         div_ack;
   logic         oneshot;
   logic         start;
   logic         tick;
   logic         sq_out;
   logic [W-1:0] count;
   logic         busy;

   int total = 0;
   int bad   = 0;
   int c_exp = 0;

   typedef struct packed {
      logic         t;
      logic [W-1:0] c;
      logic         b;
      logic         a;
      logic         s;
   } exp_t;

   exp_t sb[$];

   clock_tick_divider #(
      .WIDTH       (W),
      .DEFAULT_DIV (5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .div_val  (div_val),
      .div_load (div_load),
      .div_ack  (div_ack),
      .oneshot  (oneshot),
      .start    (start),
      .tick     (tick),
      .sq_out   (sq_out),
      .count    (count),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push the expected outputs for the coming edge, then pop and compare once it has happened.
   task automatic step(input logic t, input int c, input logic b, input logic a, input int n);
      exp_t e;
      e.t = t;
      e.c = W'(c);
      e.b = b;
      e.a = a;
`ifdef DIVIDER_SQUARE_EN
      e.s = b && (c < n / 2);
`else
      e.s = 1'b0;
`endif
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("tick", 32'(tick), 32'(e.t));
      chk("count", 32'(count), 32'(e.c));
      chk("busy", 32'(busy), 32'(e.b));
      chk("div_ack", 32'(div_ack), 32'(e.a));
      chk("sq_out", 32'(sq_out), 32'(e.s));
   endtask

   // One enabled edge in continuous RUN with divisor n.
   task automatic adv(input int n, input logic a);
      c_exp = (c_exp + 1) % n;
      step(c_exp == 0, c_exp, 1'b1, a, n);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_tick"}, 32'(tick), 32'd0);
      chk({tag, "_ack"}, 32'(div_ack), 32'd0);
      chk({tag, "_sq"}, 32'(sq_out), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   initial begin
      rst_n    = 1'b1;
      en       = 1'b1;
      div_val  = '0;
      div_load = 1'b0;
      oneshot  = 1'b0;
      start    = 1'b0;
      #2 rst_n = 1'b0;
      #10;
      chk_reset("rst");
      rst_n = 1'b1;

      // Default divisor 5: ticks at edges 5, 10, 15.
      c_exp = 0;
      for (int i = 0; i < 15; i++) adv(5, 1'b0);

      // Load 3 at count 1: period finishes with 5, ack with tick, then period 3.
      adv(5, 1'b0);
      div_val = 8'd3; div_load = 1'b1;
      adv(5, 1'b0);
      div_load = 1'b0;
      adv(5, 1'b0);
      adv(5, 1'b0);
      adv(5, 1'b1);
      for (int i = 0; i < 6; i++) adv(3, 1'b0);

      // A zero divisor request is ignored.
      div_val = 8'd0; div_load = 1'b1;
      adv(3, 1'b0);
      div_load = 1'b0;
      adv(3, 1'b0);
      adv(3, 1'b0);

      // Loads of 7 then 4 inside one period: one ack, divisor 4.
      div_val = 8'd7; div_load = 1'b1;
      adv(3, 1'b0);
      div_val = 8'd4;
      adv(3, 1'b0);
      div_load = 1'b0;
      adv(3, 1'b1);
      for (int i = 0; i < 4; i++) adv(4, 1'b0);

      // Switch to 6, then one-shot: the next wrap ends in IDLE.
      div_val = 8'd6; div_load = 1'b1;
      adv(4, 1'b0);
      div_load = 1'b0;
      adv(4, 1'b0);
      adv(4, 1'b0);
      adv(4, 1'b1);
      oneshot = 1'b1;
      for (int i = 0; i < 5; i++) adv(6, 1'b0);
      step(1'b1, 0, 1'b0, 1'b0, 6);
      step(1'b0, 0, 1'b0, 1'b0, 6);
      step(1'b0, 0, 1'b0, 1'b0, 6);

      // start from IDLE: busy at once, single tick N edges later.
      start = 1'b1;
      step(1'b0, 0, 1'b1, 1'b0, 6);
      start = 1'b0;
      c_exp = 0;
      for (int i = 0; i < 5; i++) adv(6, 1'b0);
      step(1'b1, 0, 1'b0, 1'b0, 6);
      step(1'b0, 0, 1'b0, 1'b0, 6);

      // Restart inside RUN, with en low on the restart edge.
      start = 1'b1;
      step(1'b0, 0, 1'b1, 1'b0, 6);
      start = 1'b0;
      c_exp = 0;
      for (int i = 0; i < 3; i++) adv(6, 1'b0);
      start = 1'b1; en = 1'b0;
      step(1'b0, 0, 1'b1, 1'b0, 6);
      start = 1'b0; en = 1'b1;
      c_exp = 0;
      for (int i = 0; i < 5; i++) adv(6, 1'b0);
      step(1'b1, 0, 1'b0, 1'b0, 6);

      // Divisor load while IDLE is applied on the next edge.
      div_val = 8'd5; div_load = 1'b1;
      step(1'b0, 0, 1'b0, 1'b0, 5);
      div_load = 1'b0;
      step(1'b0, 0, 1'b0, 1'b1, 5);
      oneshot = 1'b0;
      step(1'b0, 0, 1'b1, 1'b0, 5);
      c_exp = 0;

      // Pause at count 2 for 10 cycles, then 3 enabled cycles to the tick.
      adv(5, 1'b0);
      adv(5, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 10; i++) step(1'b0, 2, 1'b1, 1'b0, 5);
      en = 1'b1;
      for (int i = 0; i < 3; i++) adv(5, 1'b0);

      // Asynchronous reset at count 3 with a load of 2 pending.
      adv(5, 1'b0);
      div_val = 8'd2; div_load = 1'b1;
      adv(5, 1'b0);
      div_load = 1'b0;
      adv(5, 1'b0);
      chk("pre_rst_count", 32'(count), 32'd3);
      #3 rst_n = 1'b0;
      #1;
      chk_reset("arst");
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_reset("arst_hold");
      rst_n = 1'b1;
      c_exp = 0;
      for (int i = 0; i < 10; i++) adv(5, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clock_tick_divider.md
# clock_tick_divider

Programmable synchronous divider that replaces ripple-clocked divider chains. All state is in the `clk` domain: no derived clocks, only a one-cycle `tick` enable, an optional square wave and a live count. It drives display scan, blink and game timers. Divisor, pause and one-shot mode are run-time controls.

## Interface
- `WIDTH`, 24, width of the counter and divisor; range 2..32.
- `DEFAULT_DIV`, 50000, divisor loaded at reset; must satisfy 1 ≤ value < 2^WIDTH.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  count enable; low pauses the counter, which holds its value.
- `div_val`  in  WIDTH  requested divisor N.
- `div_load`  in  1  one-cycle request to load `div_val`.
- `div_ack`  out  1  one-cycle pulse when the pending divisor becomes active.
- `oneshot`  in  1  mode: 0 = continuous, 1 = one-shot.
- `start`  in  1  arms one-shot mode from IDLE; restarts the period when in RUN.
- `tick`  out  1  one-cycle pulse per completed period.
- `sq_out`  out  1  square wave with period N.
- `count`  out  WIDTH  current phase, 0..N-1.
- `busy`  out  1  high in state RUN.

## Operation
- Registers:
  - `div_r`: active divisor.
  - `pend_r` / `pend_v`: pending divisor and its valid flag.
  - `count`
  - state: IDLE or RUN.
- Divisor load:
  - `div_load` with `div_val`=0 is ignored: no pending entry, no ack.
  - Otherwise `pend_r` ← `div_val` and `pend_v` ← 1.
  - A load arriving while a value is already pending overwrites it; the latest value wins and only one ack is issued.
- Pending divisor is applied (`div_r` ← `pend_r`, `div_ack`=1, `pend_v` ← 0):
  - at a period wrap, or
  - on the next edge when in IDLE, or
  - on a `start` restart.
  - This guarantees the active divisor never changes mid-period.
- RUN, on each edge with `en`=1:
  - If `count` = `div_r`-1: `count` ← 0 and `tick` ← 1.
  - Otherwise: `count` ← `count`+1 and `tick` ← 0.
- RUN with `en`=0: `count` holds and `tick` ← 0.
- N=1: `tick` is high on every enabled cycle.
- State transitions:
  - RUN with `oneshot`=1: at the first wrap, go to IDLE. `tick` still pulses for that wrap.
  - IDLE with `oneshot`=0: go to RUN on the next edge.
  - IDLE with `oneshot`=1: go to RUN when `start`=1.
  - Entering RUN always sets `count`=0.
- `start` in RUN (either mode):
  - `count` ← 0 and `tick` ← 0; `en` is ignored on that edge.
  - `start` has priority over a simultaneous wrap.
- In IDLE: `count`=0, `tick`=0, `sq_out`=0, `busy`=0.
- `sq_out` is registered and ← (`count_next` < `div_r`>>1):
  - high for floor(N/2) cycles, low for ceil(N/2) cycles;
  - constant 0 for N=1.

## Timing
- Reset values:
  - `count`=0, `tick`=0, `div_ack`=0, `sq_out`=0, `busy`=1 (state RUN);
  - `div_r`=`DEFAULT_DIV`, `pend_v`=0.
- Asserting `rst_n` mid-period clears everything immediately and drops any pending load.
- With `en` held high after reset release, the first `tick` is high in the cycle after the N-th rising edge, then every N cycles.
- `tick`, `div_ack` and `sq_out` are registered outputs with zero combinational paths from inputs.
- `div_ack` coincides with the `tick` of the wrap that applied the divisor. The next period already uses the new N.
- One-shot: `start` sampled at edge k → `busy` high from k; `tick` at edge k+N; `busy` low after edge k+N.
- Counter arithmetic is modulo `div_r`. `count` never reaches `div_r`, and no WIDTH overflow is possible.

## Configuration
- `DIVIDER_SQUARE_EN`:
  - defined: `sq_out` logic is implemented as described;
  - undefined: `sq_out` is tied to 0 and its compare logic is removed.
- `tick`, `count` and all other behaviour are identical in both builds.

## Test plan
- Reset, DEFAULT_DIV=5, `en`=1 → `tick` at edges 5, 10, 15; `count` runs 0,1,2,3,4,0; `sq_out` (macro on) is high 2 cycles, low 3 cycles.
- `div_load`=1, `div_val`=3 at `count`=1 of N=5 → period completes with N=5; `div_ack` and `tick` coincide; the next ticks are 3 cycles apart.
- `div_val`=0 load → no `div_ack`, period unchanged. Loads of 7 then 4 in one period → a single ack, N=4.
- `oneshot`=1, `start` at edge 20 with N=6 → `busy` high edges 20..26, a single `tick` at 26, then IDLE with `count`=0.
- `en` low for 10 cycles at `count`=2 (N=5) → `count` holds at 2 and no tick; the next tick comes 3 enabled cycles after resuming.
- `rst_n` low at `count`=3 with a load pending → outputs go to reset values asynchronously; `div_r` returns to DEFAULT_DIV and no `div_ack` is issued.
